// File: rtl/codec_config_sequencer.sv
// Power-up configuration sequencer for an I2C audio codec: writes a fixed
// 10-entry register table over an open-drain I2C bus, retrying on NACK.
module codec_config_sequencer #(
  parameter int         CLK_DIV   = 125,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  output logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       busy,
  output logic       config_done,
  output logic       config_error,
  output logic [3:0] reg_index
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_NEXT, S_DONE, S_ERROR
  } state_t;

  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = {7'h00, 9'h017};
      4'd1:    table_entry = {7'h01, 9'h017};
      4'd2:    table_entry = {7'h02, 9'h079};
      4'd3:    table_entry = {7'h03, 9'h079};
      4'd4:    table_entry = {7'h04, 9'h015};
      4'd5:    table_entry = {7'h05, 9'h000};
      4'd6:    table_entry = {7'h06, 9'h000};
      4'd7:    table_entry = {7'h07, 9'h04D};
      4'd8:    table_entry = {7'h08, 9'h000};
      default: table_entry = {7'h09, 9'h001};
    endcase
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [1:0]         r_qtr, w_qtr_nxt;
  logic [2:0]         r_bit, w_bit_nxt;
  logic [1:0]         r_byte, w_byte_nxt;
  logic [3:0]         r_idx, w_idx_nxt;
  logic [RETRY_W-1:0] r_retry, w_retry_nxt;
  logic               r_ack_ok, w_ack_ok_nxt;
  logic               r_success, w_success_nxt;
  logic               r_busy;
  logic               r_scl, w_scl;
  logic               r_sda_pre, r_sda_oe, w_sda_oe;
  logic [1:0]         r_sda_sync;
  logic               w_tick;
  logic [15:0]        w_entry;
  logic [7:0]         w_byte_val;
  logic               w_tx_bit;

  assign w_tick = r_busy && (r_tick_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                 r_tick_cnt <= '0;
    else if (!r_busy || w_tick)  r_tick_cnt <= '0;
    else                         r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign w_entry = table_entry(r_idx);

  always_comb begin
    case (r_byte)
      2'd0:    w_byte_val = {DEV_ADDR, 1'b0};
      2'd1:    w_byte_val = w_entry[15:8];
      default: w_byte_val = w_entry[7:0];
    endcase
  end

  assign w_tx_bit = w_byte_val[r_bit];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_qtr_nxt     = r_qtr;
    w_bit_nxt     = r_bit;
    w_byte_nxt    = r_byte;
    w_idx_nxt     = r_idx;
    w_retry_nxt   = r_retry;
    w_ack_ok_nxt  = r_ack_ok;
    w_success_nxt = r_success;
    w_scl         = 1'b1;
    w_sda_oe      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_START;
          w_qtr_nxt   = '0;
        end
      end
      S_START: begin
        w_sda_oe = 1'b1;
        if (w_tick) begin
          if (r_qtr == 2'd1) begin
            w_state_nxt = S_BIT;
            w_qtr_nxt   = '0;
            w_byte_nxt  = '0;
            w_bit_nxt   = 3'd7;
          end else begin
            w_qtr_nxt = r_qtr + 1'b1;
          end
        end
      end
      S_BIT: begin
        w_scl    = r_qtr[1];
        w_sda_oe = ~w_tx_bit;
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd3) begin
            if (r_bit == 3'd0) w_state_nxt = S_ACK;
            else               w_bit_nxt   = r_bit - 1'b1;
          end
        end
      end
      S_ACK: begin
        w_scl = r_qtr[1];
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd2) w_ack_ok_nxt = ~r_sda_sync[1];
          if (r_qtr == 2'd3) begin
            if (!r_ack_ok) begin
              w_state_nxt   = S_STOP;
              w_success_nxt = 1'b0;
            end else if (r_byte == 2'd2) begin
              w_state_nxt   = S_STOP;
              w_success_nxt = 1'b1;
            end else begin
              w_state_nxt = S_BIT;
              w_byte_nxt  = r_byte + 1'b1;
              w_bit_nxt   = 3'd7;
            end
          end
        end
      end
      S_STOP: begin
        // SDA low while SCL rises in quarter 2, released in quarter 3.
        w_scl    = r_qtr[1];
        w_sda_oe = (r_qtr != 2'd3);
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd3) w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_tick) begin
          w_qtr_nxt = r_qtr + 1'b1;
          if (r_qtr == 2'd3) begin
            if (r_success) begin
              if (r_idx == 4'd9) begin
                w_state_nxt = S_DONE;
              end else begin
                w_state_nxt = S_START;
                w_idx_nxt   = r_idx + 1'b1;
                w_retry_nxt = '0;
              end
            end else if (r_retry < RETRY_LAST) begin
              w_state_nxt = S_START;
              w_retry_nxt = r_retry + 1'b1;
            end else begin
              w_state_nxt = S_ERROR;
            end
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_retry_nxt = '0;
          w_qtr_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_qtr      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_ack_ok   <= 1'b0;
      r_success  <= 1'b0;
      r_busy     <= 1'b0;
      r_scl      <= 1'b1;
      r_sda_pre  <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_sda_sync <= 2'b11;
    end else begin
      r_state    <= w_state_nxt;
      r_qtr      <= w_qtr_nxt;
      r_bit      <= w_bit_nxt;
      r_byte     <= w_byte_nxt;
      r_idx      <= w_idx_nxt;
      r_retry    <= w_retry_nxt;
      r_ack_ok   <= w_ack_ok_nxt;
      r_success  <= w_success_nxt;
      r_busy     <= !((w_state_nxt == S_DONE) || (w_state_nxt == S_ERROR));
      r_scl      <= w_scl;
      // Extra SDA stage gives one cycle of hold after each SCL falling edge.
      r_sda_pre  <= w_sda_oe;
      r_sda_oe   <= r_sda_pre;
      r_sda_sync <= {r_sda_sync[0], I2C_SDAT};
    end
  end

  assign I2C_SCLK     = r_scl;
  assign I2C_SDAT     = r_sda_oe ? 1'b0 : 1'bz;
  assign busy         = r_busy;
  assign config_done  = (r_state == S_DONE);
  assign config_error = (r_state == S_ERROR);
  assign reg_index    = r_idx;

endmodule
